buffer2axis: RTL and testbench

- Transmit-side counterpart of the conware AXIS input path.
- Accepts one full WIDTH*HEIGHT-bit cell frame from the conware computation through a valid/ready handshake, then snapshots it.
- Streams the frame out as an AXI4-Stream master, one beat per cell, mapping each cell bit to alive_color or dead_color.
- Sits between the computation core and the outbound DMA/VDMA stream.

---
 rtl/conware_pkg.sv | 21 ++
 rtl/cell2color.sv | 21 ++
 rtl/buffer2axis.sv | 123 ++++++++++++
 tb/tb_buffer2axis.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conware_pkg.sv
// rtl/conware_pkg.sv - shared conware definitions for the transmit and receive stream blocks
//
// Purpose: holds the default frame geometry, the default pixel colors and the
// two-state transfer FSM encoding. The receive-side block uses the same values.
// Ports: none (package).

package conware_pkg;

    localparam int DWIDTH_DEFAULT = 32;
    localparam int WIDTH_DEFAULT  = 4;
    localparam int HEIGHT_DEFAULT = 4;

    localparam logic [31:0] ALIVE_DEFAULT = 32'h00FF_FFFF;
    localparam logic [31:0] DEAD_DEFAULT  = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/cell2color.sv
// rtl/cell2color.sv - maps one cell bit to its pixel color
//
// Purpose: purely combinational select between the alive and dead colors.
// Ports:
//   cell_i  - cell state, 1 = alive
//   alive_i - color driven when the cell is alive
//   dead_i  - color driven when the cell is dead
//   color_o - selected pixel value

module cell2color #(
    parameter int DWIDTH = 32
) (
    input  logic              cell_i,
    input  logic [DWIDTH-1:0] alive_i,
    input  logic [DWIDTH-1:0] dead_i,
    output logic [DWIDTH-1:0] color_o
);

    assign color_o = cell_i ? alive_i : dead_i;

endmodule

// File: rtl/buffer2axis.sv
// rtl/buffer2axis.sv - snapshots a conware cell frame and streams it as AXI4-Stream pixels
//
// Purpose: accepts one WIDTH*HEIGHT-bit frame through a valid/ready handshake,
// snapshots it together with the current colors, then emits one beat per cell
// (bit 0 first) with TLAST on the final cell.
// Optional feature: define BUFFER2AXIS_TUSER_EN to add M_AXIS_TUSER, which marks
// the first beat of each frame (start-of-frame).
// Ports:
//   clk, rstn                  - clock, asynchronous active-low reset
//   alive_color, dead_color    - pixel values for cell bits 1 and 0
//   in_data, in_valid, in_ready- frame input handshake
//   M_AXIS_TDATA/TVALID/TREADY/TLAST - pixel stream master
//   M_AXIS_TUSER               - start-of-frame flag (BUFFER2AXIS_TUSER_EN only)

module buffer2axis
    import conware_pkg::*;
#(
    parameter  int DWIDTH = DWIDTH_DEFAULT,
    parameter  int WIDTH  = WIDTH_DEFAULT,
    parameter  int HEIGHT = HEIGHT_DEFAULT,
    localparam int N      = WIDTH * HEIGHT,
    localparam int CNT_W  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DWIDTH-1:0] alive_color,
    input  logic [DWIDTH-1:0] dead_color,
    input  logic [N-1:0]      in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
`ifdef BUFFER2AXIS_TUSER_EN
    output logic              M_AXIS_TUSER,
`endif
    output logic              M_AXIS_TLAST
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [N-1:0]      snap_q,  snap_d;
    logic [DWIDTH-1:0] alive_q, alive_d;
    logic [DWIDTH-1:0] dead_q,  dead_d;

    logic              sending;
    logic              last_beat;
    logic [DWIDTH-1:0] pixel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            alive_q <= '0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            alive_q <= alive_d;
            dead_q  <= dead_d;
        end
    end

    // Colors are latched with the frame so that color changes upstream only
    // take effect on the next frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        alive_d = alive_q;
        dead_d  = dead_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    snap_d  = in_data;
                    alive_d = alive_color;
                    dead_d  = dead_color;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (M_AXIS_TREADY) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sending   = (state_q == ST_SEND);
    assign last_beat = (cnt_q == LAST_CNT);

    cell2color #(
        .DWIDTH (DWIDTH)
    ) u_cell2color (
        .cell_i  (snap_q[cnt_q]),
        .alive_i (alive_q),
        .dead_i  (dead_q),
        .color_o (pixel)
    );

    // Stream outputs depend only on registered state, so a stall cannot
    // disturb them and TREADY never reaches TVALID.
    assign in_ready      = ~sending;
    assign M_AXIS_TVALID = sending;
    assign M_AXIS_TLAST  = sending & last_beat;
    assign M_AXIS_TDATA  = sending ? pixel : '0;

`ifdef BUFFER2AXIS_TUSER_EN
    assign M_AXIS_TUSER  = sending & (cnt_q == '0);
`endif

endmodule

// File: tb/tb_buffer2axis.sv
// tb/tb_buffer2axis.sv - self-checking bench for buffer2axis

`timescale 1ns/1ps

module tb_buffer2axis;
    import conware_pkg::*;

    localparam int DW = 32;
    localparam int N  = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] alive_color, dead_color;
    logic [N-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] tdata;
    logic          tvalid, tready, tlast;
`ifdef BUFFER2AXIS_TUSER_EN
    logic          tuser;
`endif

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    buffer2axis #(.DWIDTH(DW), .WIDTH(4), .HEIGHT(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .alive_color   (alive_color),
        .dead_color    (dead_color),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TREADY (tready),
`ifdef BUFFER2AXIS_TUSER_EN
        .M_AXIS_TUSER  (tuser),
`endif
        .M_AXIS_TLAST  (tlast)
    );

    task automatic push_frame(input logic [N-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] d);
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.data = f[i] ? a : d;
            b.last = (i == N - 1);
            b.user = (i == 0);
            exp_q.push_back(b);
        end
    endtask

    task automatic compare_beat(input string tag);
        beat_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_extra_beat got data=%h last=%b want none", tag, tdata, tlast);
        end else begin
            e = exp_q.pop_front();
            if (tdata !== e.data || tlast !== e.last) begin
                bad++;
                $display("FAIL %s_beat got data=%h last=%b want data=%h last=%b", tag, tdata, tlast, e.data, e.last);
            end
`ifdef BUFFER2AXIS_TUSER_EN
            total++;
            if (tuser !== e.user) begin
                bad++;
                $display("FAIL %s_tuser got %b want %b", tag, tuser, e.user);
            end
`endif
        end
    endtask

    task automatic start_frame(input logic [N-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        in_data = f; alive_color = a; dead_color = d; in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_in_ready got %b want 1", in_ready);
        end
        push_frame(f, a, d);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Accepts nbeats beats; TREADY random when rnd, alive_color changed
    // upstream once change_at beats have been accepted.
    task automatic drain(input string tag, input int nbeats, input bit rnd,
                         input int change_at, input logic [DW-1:0] new_alive);
        int            got = 0;
        int            cyc = 0;
        logic          stalled = 1'b0;
        logic [DW-1:0] sd = '0;
        logic          sl = 1'b0;
        while (got < nbeats && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                total++;
                if (tdata !== sd || tlast !== sl || tvalid !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_stall_hold got data=%h last=%b valid=%b want data=%h last=%b valid=1",
                             tag, tdata, tlast, tvalid, sd, sl);
                end
            end
            total++;
            if (in_ready !== ~tvalid) begin
                bad++;
                $display("FAIL %s_in_ready got %b want %b", tag, in_ready, ~tvalid);
            end
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tvalid && tready) begin
                compare_beat(tag);
                got++;
                if (got == change_at) alive_color = new_alive;
                stalled = 1'b0;
            end else begin
                stalled = tvalid;
                sd = tdata;
                sl = tlast;
            end
        end
        total++;
        if (got != nbeats) begin
            bad++;
            $display("FAIL %s_timeout got %0d beats want %0d", tag, got, nbeats);
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        total++;
        if (tvalid !== 1'b0 || in_ready !== 1'b1 || tlast !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_idle got valid=%b ready=%b last=%b pending=%0d want 0 1 0 0",
                     tag, tvalid, in_ready, tlast, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; tready = 1'b0;
        alive_color = ALIVE_DEFAULT; dead_color = DEAD_DEFAULT;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== '0) begin
            bad++;
            $display("FAIL reset_values got ready=%b valid=%b last=%b data=%h want 1 0 0 0",
                     in_ready, tvalid, tlast, tdata);
        end
    endtask

    task automatic test_basic;
        start_frame(16'hA5C3, ALIVE_DEFAULT, DEAD_DEFAULT);
        drain("basic", N, 1'b0, -1, '0);
        check_idle("basic");
    endtask

    task automatic test_stall;
        start_frame(16'hA5C3, ALIVE_DEFAULT, DEAD_DEFAULT);
        drain("stall", N, 1'b1, -1, '0);
        check_idle("stall");
    endtask

    task automatic test_color_change;
        start_frame(16'h3C96, ALIVE_DEFAULT, DEAD_DEFAULT);
        drain("color_old", N, 1'b0, 5, 32'h00FF_0000);
        check_idle("color_old");
        start_frame(16'h3C96, alive_color, DEAD_DEFAULT);
        total++;
        if (exp_q[0].data !== 32'h0 || exp_q[1].data !== 32'h00FF_0000) begin
            bad++;
            $display("FAIL color_upstream got alive=%h want 00ff0000", alive_color);
        end
        drain("color_new", N, 1'b0, -1, '0);
        check_idle("color_new");
        alive_color = ALIVE_DEFAULT;
    endtask

    task automatic test_back_to_back;
        logic exp_valid;
        @(negedge clk);
        in_data = 16'hFFFF; in_valid = 1'b1; tready = 1'b1;
        push_frame(16'hFFFF, ALIVE_DEFAULT, DEAD_DEFAULT);
        push_frame(16'h0001, ALIVE_DEFAULT, DEAD_DEFAULT);
        for (int k = 0; k <= 2 * N + 1; k++) begin
            @(negedge clk);
            if (k == 0) in_data = 16'h0001;
            exp_valid = (k != N) && (k != 2 * N + 1);
            total++;
            if (tvalid !== exp_valid || in_ready !== ~exp_valid) begin
                bad++;
                $display("FAIL b2b_gap k=%0d got valid=%b ready=%b want valid=%b", k, tvalid, in_ready, exp_valid);
            end
            if (tvalid) compare_beat("b2b");
            if (k == N + 1) in_valid = 1'b0;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_pending got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        start_frame(16'hA5C3, ALIVE_DEFAULT, DEAD_DEFAULT);
        drain("abort", 7, 1'b0, -1, '0);
        @(negedge clk);
        tready = 1'b0;
        total++;
        if (tvalid !== 1'b1 || tdata !== exp_q[0].data) begin
            bad++;
            $display("FAIL abort_beat7 got valid=%b data=%h want 1 %h", tvalid, tdata, exp_q[0].data);
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || in_ready !== 1'b1 || tdata !== '0) begin
            bad++;
            $display("FAIL async_reset got valid=%b last=%b ready=%b data=%h want 0 0 1 0",
                     tvalid, tlast, in_ready, tdata);
        end
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        start_frame(16'h0001, ALIVE_DEFAULT, DEAD_DEFAULT);
        @(negedge clk);
        total++;
        if (tvalid !== 1'b1 || tdata !== ALIVE_DEFAULT || tlast !== 1'b0) begin
            bad++;
            $display("FAIL restart_first got valid=%b data=%h last=%b want 1 %h 0",
                     tvalid, tdata, tlast, ALIVE_DEFAULT);
        end
        drain("restart", N, 1'b0, -1, '0);
        check_idle("restart");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_color_change();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
